// File: rtl/reg_bank_gen.sv
// Nibble-wide register bank: jump register, output register, program counter,
// optional return stack (compiled in with `define REG_BANK_STACK_EN).
module reg_bank_gen #(
  parameter int unsigned NIB_W     = 4,
  parameter int unsigned PA_NIBS   = 2,
  parameter int unsigned OR_NIBS   = 2,
  parameter int unsigned IR_NIBS   = 2,
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NIB_W-1:0]           STOREBUS,
  input  logic                       ST_EN,
  input  logic [7:0]                 ST_SEL,
  input  logic                       OUT_EN,
  input  logic [7:0]                 OUT_SEL,
  output logic [NIB_W-1:0]           LOADBUS,
  output logic                       LOADBUS_OE,
  input  logic                       PC_INC,
  input  logic                       PC_LD,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [IR_NIBS*NIB_W-1:0]   IR,
  output logic [PA_NIBS*NIB_W-1:0]   PA,
  output logic [OR_NIBS*NIB_W-1:0]   OR,
  output logic                       STK_ERR
);

  localparam int unsigned PA_W = PA_NIBS * NIB_W;
  localparam int unsigned OR_W = OR_NIBS * NIB_W;

  logic [PA_W-1:0] jr_q;
  logic [PA_W-1:0] pc_q;
  logic [OR_W-1:0] or_q;

  // Nibble stores into JR and OR
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      jr_q <= '0;
      or_q <= '0;
    end else if (ST_EN) begin
      for (int unsigned k = 0; k < PA_NIBS; k++) begin
        if (ST_SEL == 8'(k)) begin
          jr_q[k*NIB_W +: NIB_W] <= STOREBUS;
        end
      end
      for (int unsigned k = 0; k < OR_NIBS; k++) begin
        if (ST_SEL == 8'(PA_NIBS + k)) begin
          or_q[k*NIB_W +: NIB_W] <= STOREBUS;
        end
      end
    end
  end

  // Load bus reads pre-edge register contents, so a same-cycle store is not visible
  always_comb begin
    LOADBUS    = '0;
    LOADBUS_OE = 1'b0;
    if (OUT_EN) begin
      for (int unsigned k = 0; k < PA_NIBS; k++) begin
        if (OUT_SEL == 8'(k)) begin
          LOADBUS    = jr_q[k*NIB_W +: NIB_W];
          LOADBUS_OE = 1'b1;
        end
      end
      for (int unsigned k = 0; k < IR_NIBS; k++) begin
        if (OUT_SEL == 8'(PA_NIBS + k)) begin
          LOADBUS    = IR[k*NIB_W +: NIB_W];
          LOADBUS_OE = 1'b1;
        end
      end
    end
  end

`ifdef REG_BANK_STACK_EN
  localparam int unsigned SP_W = $clog2(STK_DEPTH + 1);

  logic [SP_W-1:0] sp_q;
  logic [PA_W-1:0] stk_q [STK_DEPTH];
  logic            err_q;
  logic [PA_W-1:0] top_c;
  logic            full_c;
  logic            empty_c;

  assign full_c  = (sp_q == SP_W'(STK_DEPTH));
  assign empty_c = (sp_q == '0);

  // Top-of-stack entry sits just below the stack pointer
  always_comb begin
    top_c = '0;
    for (int unsigned e = 0; e < STK_DEPTH; e++) begin
      if (sp_q == SP_W'(e + 1)) begin
        top_c = stk_q[e];
      end
    end
  end

  // PC update with RET > CALL > PC_LD > PC_INC priority
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned e = 0; e < STK_DEPTH; e++) begin
        stk_q[e] <= '0;
      end
    end else if (RET) begin
      if (!empty_c) begin
        pc_q <= top_c;
        sp_q <= sp_q - SP_W'(1);
      end else begin
        err_q <= 1'b1;
      end
    end else if (CALL) begin
      if (!full_c) begin
        for (int unsigned e = 0; e < STK_DEPTH; e++) begin
          if (sp_q == SP_W'(e)) begin
            stk_q[e] <= pc_q + PA_W'(1);
          end
        end
        sp_q <= sp_q + SP_W'(1);
      end else begin
        err_q <= 1'b1;
      end
      pc_q <= jr_q;
    end else if (PC_LD) begin
      pc_q <= jr_q;
    end else if (PC_INC) begin
      pc_q <= pc_q + PA_W'(1);
    end
  end

  assign STK_ERR = err_q;
`else
  logic unused_c;

  // Stack controls have no effect in this build
  assign unused_c = CALL ^ RET ^ (STK_DEPTH == 0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= '0;
    end else if (PC_LD) begin
      pc_q <= jr_q;
    end else if (PC_INC) begin
      pc_q <= pc_q + PA_W'(1);
    end
  end

  assign STK_ERR = 1'b0;
`endif

  assign PA = pc_q;
  assign OR = or_q;

endmodule

// File: tb/tb_reg_bank_gen.sv
// Scoreboard bench for reg_bank_gen; stack scenarios become PC-only behaviour
// when REG_BANK_STACK_EN is undefined.
module tb_reg_bank_gen;

  logic       CLK;
  logic       RST;
  logic [3:0] STOREBUS;
  logic       ST_EN;
  logic [7:0] ST_SEL;
  logic       OUT_EN;
  logic [7:0] OUT_SEL;
  logic [3:0] LOADBUS;
  logic       LOADBUS_OE;
  logic       PC_INC;
  logic       PC_LD;
  logic       CALL;
  logic       RET;
  logic [7:0] IR;
  logic [7:0] PA;
  logic [7:0] OR;
  logic       STK_ERR;

  reg_bank_gen dut (
    .CLK(CLK), .RST(RST), .STOREBUS(STOREBUS), .ST_EN(ST_EN), .ST_SEL(ST_SEL),
    .OUT_EN(OUT_EN), .OUT_SEL(OUT_SEL), .LOADBUS(LOADBUS), .LOADBUS_OE(LOADBUS_OE),
    .PC_INC(PC_INC), .PC_LD(PC_LD), .CALL(CALL), .RET(RET), .IR(IR),
    .PA(PA), .OR(OR), .STK_ERR(STK_ERR)
  );

  typedef struct {
    string      tag;
    logic [7:0] pa;
    logic [7:0] or_v;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] stk_m[$];
  logic [7:0] pc_m, jr_m, or_m;
  logic       err_m;
  int         n_checks = 0;
  int         n_fail   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {oe, bus} for the load mux
  function automatic logic [4:0] lb_model(input logic [7:0] jr, input logic [7:0] ir,
                                          input logic en, input logic [7:0] sel);
    if (!en) return 5'h00;
    case (sel)
      8'd0:    return {1'b1, jr[3:0]};
      8'd1:    return {1'b1, jr[7:4]};
      8'd2:    return {1'b1, ir[3:0]};
      8'd3:    return {1'b1, ir[7:4]};
      default: return 5'h00;
    endcase
  endfunction

  task automatic model_reset();
    pc_m = 8'h00; jr_m = 8'h00; or_m = 8'h00; err_m = 1'b0;
    stk_m.delete();
  endtask

  task automatic lb_check(input string tag, input logic en, input logic [7:0] sel);
    logic [4:0] e;
    OUT_EN = en; OUT_SEL = sel;
    #1;
    e = lb_model(jr_m, IR, en, sel);
    check({tag, ".LOADBUS"}, 32'(LOADBUS), 32'(e[3:0]));
    check({tag, ".OE"}, 32'(LOADBUS_OE), 32'(e[4]));
  endtask

  // Drive one clock of strobes, predict the post-edge state, compare after the edge
  task automatic cycle(input string tag, input logic st_en, input logic [7:0] st_sel,
                       input logic [3:0] sbus, input logic inc, input logic ld,
                       input logic call, input logic ret);
    exp_t       e;
    logic [7:0] jr_old;
    logic [4:0] lb;
    ST_EN = st_en; ST_SEL = st_sel; STOREBUS = sbus;
    PC_INC = inc; PC_LD = ld; CALL = call; RET = ret;
    jr_old = jr_m;
    if (OUT_EN) begin
      #1;
      lb = lb_model(jr_old, IR, OUT_EN, OUT_SEL);
      check({tag, ".LOADBUS"}, 32'(LOADBUS), 32'(lb[3:0]));
    end
`ifdef REG_BANK_STACK_EN
    if (ret) begin
      if (stk_m.size() > 0) pc_m = stk_m.pop_back();
      else err_m = 1'b1;
    end else if (call) begin
      if (stk_m.size() < 4) stk_m.push_back(pc_m + 8'd1);
      else err_m = 1'b1;
      pc_m = jr_old;
    end else
`endif
    if (ld) pc_m = jr_old;
    else if (inc) pc_m = pc_m + 8'd1;
    if (st_en) begin
      case (st_sel)
        8'd0: jr_m[3:0] = sbus;
        8'd1: jr_m[7:4] = sbus;
        8'd2: or_m[3:0] = sbus;
        8'd3: or_m[7:4] = sbus;
        default: ;
      endcase
    end
    e.tag = tag; e.pa = pc_m; e.or_v = or_m; e.err = err_m;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".PA"}, 32'(PA), 32'(e.pa));
    check({e.tag, ".OR"}, 32'(OR), 32'(e.or_v));
    check({e.tag, ".STK_ERR"}, 32'(STK_ERR), 32'(e.err));
    ST_EN = 1'b0; ST_SEL = 8'd0; STOREBUS = 4'h0;
    PC_INC = 1'b0; PC_LD = 1'b0; CALL = 1'b0; RET = 1'b0;
    OUT_EN = 1'b0; OUT_SEL = 8'd0;
  endtask

  task automatic load_jr(input string tag, input logic [7:0] v);
    cycle({tag, ".jr_lo"}, 1'b1, 8'd0, v[3:0], 1'b0, 1'b0, 1'b0, 1'b0);
    cycle({tag, ".jr_hi"}, 1'b1, 8'd1, v[7:4], 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_between_edges(input string tag);
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check({tag, ".PA"}, 32'(PA), 32'(pc_m));
    check({tag, ".OR"}, 32'(OR), 32'(or_m));
    check({tag, ".STK_ERR"}, 32'(STK_ERR), 32'(err_m));
  endtask

  initial begin
    RST = 1'b1; STOREBUS = 4'h0; ST_EN = 1'b0; ST_SEL = 8'd0; OUT_EN = 1'b0;
    OUT_SEL = 8'd0; PC_INC = 1'b0; PC_LD = 1'b0; CALL = 1'b0; RET = 1'b0; IR = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst.PA", 32'(PA), 32'h00);
    check("rst.OR", 32'(OR), 32'h00);
    check("rst.STK_ERR", 32'(STK_ERR), 32'h0);
    lb_check("rst.lb", 1'b0, 8'd0);
    RST = 1'b0;

    // JR assembled from two nibbles, then loaded into PC
    cycle("st_jr0", 1'b1, 8'd0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("st_jr1", 1'b1, 8'd1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("pc_ld", 1'b0, 8'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    lb_check("rd_jr0", 1'b1, 8'd0);
    lb_check("rd_jr1", 1'b1, 8'd1);
    cycle("hold", 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Output register stores and an out-of-range select
    cycle("st_or0", 1'b1, 8'd2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("st_or1", 1'b1, 8'd3, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("st_bad", 1'b1, 8'd9, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Same-cycle store and read/load of JR see the old value
    OUT_EN = 1'b1; OUT_SEL = 8'd0;
    cycle("st_ld_same", 1'b1, 8'd0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    lb_check("rd_new_jr0", 1'b1, 8'd0);

    // PC wrap and PC_LD over PC_INC priority
    load_jr("ff", 8'hFF);
    cycle("ld_ff", 1'b0, 8'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("inc_wrap", 1'b0, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("inc", 1'b0, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    load_jr("j30", 8'h30);
    cycle("inc_and_ld", 1'b0, 8'd0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Input port reads
    IR = 8'hC3;
    lb_check("ir_hi", 1'b1, 8'd3);
    lb_check("ir_lo", 1'b1, 8'd2);
    lb_check("ir_sel9", 1'b1, 8'd9);
    lb_check("ir_noen", 1'b0, 8'd3);
    IR = 8'h5E;
    lb_check("ir_hi2", 1'b1, 8'd3);
    OUT_EN = 1'b0;

    // Call/return with an underflowing second return
    load_jr("j10", 8'h10);
    cycle("ld_10", 1'b0, 8'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    load_jr("j40", 8'h40);
    cycle("call_40", 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("ret1", 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("ret_empty", 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("err_sticky", 1'b0, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("ret_beats_call", 1'b0, 8'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset clears error, then fill the stack past its depth
    reset_between_edges("rst_a");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_jr($sformatf("c%0d", i), 8'(8'h20 + 8'h10 * i));
      cycle($sformatf("call%0d", i), 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("ret%0d", i), 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Asynchronous reset between edges, strobes ignored while held
    cycle("or_77a", 1'b1, 8'd2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("or_77b", 1'b1, 8'd3, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    CALL = 1'b1; PC_INC = 1'b1; ST_EN = 1'b1; ST_SEL = 8'd2; STOREBUS = 4'hF;
    reset_between_edges("rst_b");
    @(posedge CLK);
    #1;
    check("rst_hold.PA", 32'(PA), 32'(pc_m));
    check("rst_hold.OR", 32'(OR), 32'(or_m));
    check("rst_hold.STK_ERR", 32'(STK_ERR), 32'(err_m));
    CALL = 1'b0; PC_INC = 1'b0; ST_EN = 1'b0; ST_SEL = 8'd0; STOREBUS = 4'h0;
    RST = 1'b0;
    cycle("post_rst_inc", 1'b0, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_gen.md
REG_BANK_GEN -- requirements
Module: reg_bank_gen

Interface
REQ-001 SHALL have parameter NIB_W, default 4: width of one bus nibble and of each nibble register.
REQ-002 SHALL have parameter PA_NIBS, default 2: number of nibbles in the jump register (JR), PC and PA.
REQ-003 SHALL have parameter OR_NIBS, default 2: number of output-register nibbles.
REQ-004 SHALL have parameter IR_NIBS, default 2: number of input-port nibbles.
REQ-005 SHALL have parameter STK_DEPTH, default 4: return-stack entries, 1..16.
REQ-006 SHALL have ports:
  CLK  in  1: sole clock, rising edge.
  RST  in  1: asynchronous, active-high reset.
  STOREBUS  in  NIB_W: store data.
  ST_EN  in  1: store strobe.
  ST_SEL  in  8: store target. 0..PA_NIBS-1 = JR nibble k. PA_NIBS..PA_NIBS+OR_NIBS-1 = OR nibbles. Others ignored.
  OUT_EN  in  1: load-bus drive request.
  OUT_SEL  in  8: load source. 0..PA_NIBS-1 = JR nibble. PA_NIBS..PA_NIBS+IR_NIBS-1 = IR nibble.
  LOADBUS  out  NIB_W: load data.
  LOADBUS_OE  out  1: load-bus drive enable; no internal tristate.
  PC_INC  in  1: increment PC.
  PC_LD  in  1: load PC from JR.
  CALL  in  1: push return address, jump to JR.
  RET  in  1: pop PC.
  IR  in  IR_NIBS*NIB_W: input port.
  PA  out  PA_NIBS*NIB_W: program address = PC.
  OR  out  OR_NIBS*NIB_W: output register.
  STK_ERR  out  1: sticky stack over/underflow flag.

Function
REQ-007 SHALL, on a CLK edge with ST_EN=1 and ST_SEL valid, write STOREBUS into the selected nibble; the new value is visible on OR/JR after that edge.
REQ-008 SHALL drive LOADBUS combinationally from current register or IR contents when OUT_EN=1 and OUT_SEL is valid, with LOADBUS_OE=1; otherwise LOADBUS=0 and LOADBUS_OE=0.
REQ-009 SHALL output the pre-edge JR value on LOADBUS when the same JR nibble is stored and read in the same cycle.
REQ-010 SHALL apply the PC update priority RET > CALL > PC_LD > PC_INC; at most one action per edge.
REQ-011 SHALL make PC_INC set PC to (PC+1) mod 2^(PA_NIBS*NIB_W); all ones wraps to 0.
REQ-012 SHALL make PC_LD and CALL use the pre-edge JR value, including when JR is stored in the same cycle.
REQ-013 SHALL, on CALL with stack not full, push (PC+1) mod 2^(PA_NIBS*NIB_W), load PC from JR and increment the stack pointer.
REQ-014 SHALL, on CALL with stack full, drop the push, still load PC from JR, and set STK_ERR.
REQ-015 SHALL, on RET with stack not empty, load PC from the top entry and decrement the stack pointer.
REQ-016 SHALL, on RET with stack empty, hold PC and set STK_ERR.
REQ-017 SHALL keep STK_ERR at 1 once set until RST.
REQ-018 SHALL hold PC when no PC control is active.

Reset
REQ-019 SHALL, while RST=1, immediately force PC, PA, JR, OR, the stack pointer, all stack entries and STK_ERR to 0, regardless of CLK.
REQ-020 SHALL ignore all strobes while RST=1; RST asserted mid-CALL/RET discards that operation.

Configuration
REQ-021 SHALL compile the return stack (REQ-013..REQ-017) only when macro REG_BANK_STACK_EN is defined.
REQ-022 SHALL, without REG_BANK_STACK_EN, ignore CALL and RET, tie STK_ERR to 0 and instantiate no stack storage; all other behaviour is unchanged.

Verification
REQ-023 SHALL cover: after RST, ST_SEL=0 with 0xA, then ST_SEL=1 with 0x5, then PC_LD -> PA=0x5A.
REQ-024 SHALL cover: PC=0xFF, PC_INC -> PA=0x00; PC_INC and PC_LD together with JR=0x30 -> PA=0x30.
REQ-025 SHALL cover: IR=0xC3, OUT_SEL=3, OUT_EN=1 -> LOADBUS=0xC, LOADBUS_OE=1; OUT_SEL=9 -> LOADBUS=0, LOADBUS_OE=0.
REQ-026 SHALL cover, with the macro defined: PC=0x10, JR=0x40, CALL -> PA=0x40; RET -> PA=0x11; second RET -> PA=0x11, STK_ERR=1.
REQ-027 SHALL cover, with the macro defined: five CALLs at STK_DEPTH=4 -> STK_ERR=1 on the fifth; PA=JR; four RETs return the correct addresses.
REQ-028 SHALL cover: RST asserted between edges with OR=0x77 -> OR=0x00 immediately.
